fsm_ctrl_param: RTL and testbench
=================================

# fsm_ctrl_param

Parametrised control state machine for the FIFO-based switch datapath. It sequences reset, threshold initialisation, idle and active operation over any number of FIFOs. Thresholds (umbrales) are captured during init, validated, and frozen for downstream almost-full/almost-empty logic. It sits beside the FIFO array, reading every FIFO's empty flag and driving the status outputs for the test harness and the threshold inputs of all FIFOs.

## Interface
- N_FIFO, 8, number of monitored FIFOs (inputs plus outputs); ≥1
- UMB_W, 3, threshold width in bits; ≥1
- IDLE_DLY, 4, consecutive all-empty cycles required in ACTIVE before returning to IDLE; ≥1 (1 = immediate return)

- clk  in  1  clock; all state updates on rising edge
- reset_L  in  1  asynchronous, active-low reset
- init  in  1  synchronous request to (re)enter INIT and capture thresholds
- umbral_IN_L  in  UMB_W  requested low threshold
- umbral_IN_H  in  UMB_W  requested high threshold
- empty  in  N_FIFO  per-FIFO empty flags, bit i = FIFO i empty
- umbral_OUT_L  out  UMB_W  frozen low threshold to FIFOs
- umbral_OUT_H  out  UMB_W  frozen high threshold to FIFOs
- idle_out  out  1  high in IDLE
- active_out  out  1  high in ACTIVE
- error_out  out  1  high in ERROR (invalid thresholds)
- state_out  out  3  current state encoding

## Operation
- States/encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; others unreachable; any illegal value goes to INIT next edge.
- Registers: state, umb_L, umb_H, idle_cnt (width clog2(IDLE_DLY+1)).
- reset_L low (async): state=RESET, umb_L=umb_H=0, idle_cnt=0; all outputs 0.
- Threshold capture: at every edge with init=1 (any state), umb_L<=umbral_IN_L, umb_H<=umbral_IN_H. Otherwise hold. umbral_OUT_L/H = umb_L/umb_H at all times (0 after reset).
- all_empty = AND of all empty bits.
- Transitions, evaluated in priority order per edge:
  - init=1 -> INIT (from any state, including ERROR and RESET).
  - RESET -> INIT.
  - INIT, init=0: umb_L < umb_H (unsigned) -> IDLE; else -> ERROR.
  - IDLE: all_empty -> IDLE; else -> ACTIVE, idle_cnt<=0.
  - ACTIVE: !all_empty -> ACTIVE, idle_cnt<=0. all_empty and idle_cnt==IDLE_DLY-1 -> IDLE, idle_cnt<=0. all_empty otherwise -> idle_cnt<=idle_cnt+1, stay.
  - ERROR: stay until init=1.
- Outputs are Moore, decoded from the state register only: idle_out=(state==IDLE), active_out=(state==ACTIVE), error_out=(state==ERROR), state_out=state. At most one of idle/active/error high.

## Timing
- Every output changes only on a clk edge or on async reset assertion; no combinational input-to-output path.
- Latency: an input condition sampled at edge k is visible on outputs after edge k.
- RESET lasts exactly one cycle after reset_L deasserts, unless init=1 (then INIT directly, same count).
- INIT persists while init=1; thresholds reflect the values at the last edge with init=1; exit on first edge with init=0.
- ACTIVE->IDLE: exactly IDLE_DLY consecutive all-empty edges while in ACTIVE; a single non-empty sample restarts the count.
- Simultaneous init=1 and FIFO activity: init wins.
- umb_L == umb_H is invalid (ERROR). Threshold inputs changing outside init have no effect.
- reset_L asserted mid-operation: immediate return to RESET state, thresholds cleared.

## Test plan
- Reset/init: reset_L low 3 cycles, release, init=1 2 cycles with L=2,H=5, then init=0, all empty=1 -> state 0,1,1,1,2; umbral_OUT=2/5; idle_out=1 from the cycle after init drops.
- Invalid thresholds: init with L=5,H=5 -> ERROR, error_out=1; stays with init=0 for 10 cycles; re-init L=1,H=6 -> INIT then IDLE, error_out=0.
- Idle hysteresis (IDLE_DLY=4): in IDLE, empty=8'hFE for 1 cycle -> ACTIVE next edge; then all empty -> active_out stays 1 for 4 edges, idle_out=1 after 4th.
- Count restart: in ACTIVE, all empty 3 cycles, empty=8'hBF 1 cycle, all empty 4 cycles -> IDLE only after the final 4-cycle run.
- Freeze: in IDLE, toggle umbral_IN_L/H randomly with init=0 -> umbral_OUT unchanged; assert init in ACTIVE -> INIT next edge, new values captured.
- Async reset mid-ACTIVE: drop reset_L between edges -> all outputs and umbral_OUT go to 0 immediately, without waiting for clk; repeat with N_FIFO=4, UMB_W=5, IDLE_DLY=1 (immediate ACTIVE->IDLE).

Source files
------------

// File: rtl/fsm_ctrl_param_if.sv
// fsm_ctrl_param_if - control/status bundle between the FIFO array harness
// and the switch control FSM.
//   master : drives init, requested thresholds and per-FIFO empty flags;
//            receives frozen thresholds and state/status flags
//   slave  : the FSM side (fsm_ctrl_param)
interface fsm_ctrl_param_if #(
  parameter int N_FIFO = 8,
  parameter int UMB_W  = 3
);
  logic              init;
  logic [UMB_W-1:0]  umbral_IN_L;
  logic [UMB_W-1:0]  umbral_IN_H;
  logic [N_FIFO-1:0] empty;
  logic [UMB_W-1:0]  umbral_OUT_L;
  logic [UMB_W-1:0]  umbral_OUT_H;
  logic              idle_out;
  logic              active_out;
  logic              error_out;
  logic [2:0]        state_out;

  modport master (
    output init, umbral_IN_L, umbral_IN_H, empty,
    input  umbral_OUT_L, umbral_OUT_H, idle_out, active_out, error_out, state_out
  );

  modport slave (
    input  init, umbral_IN_L, umbral_IN_H, empty,
    output umbral_OUT_L, umbral_OUT_H, idle_out, active_out, error_out, state_out
  );
endinterface

// File: rtl/fsm_ctrl_param.sv
// fsm_ctrl_param - control FSM for the FIFO-based switch datapath.
// Sequences RESET -> INIT -> IDLE <-> ACTIVE (ERROR on bad thresholds),
// captures thresholds while init is high and freezes them otherwise.
//   clk     : rising-edge clock
//   reset_L : asynchronous active-low reset
//   bus     : slave side of fsm_ctrl_param_if (init, thresholds in/out,
//             empty flags, Moore status outputs)
module fsm_ctrl_param #(
  parameter int N_FIFO   = 8,
  parameter int UMB_W    = 3,
  parameter int IDLE_DLY = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  fsm_ctrl_param_if.slave   bus
);

  localparam int CNT_W = (IDLE_DLY + 1 > 2) ? $clog2(IDLE_DLY + 1) : 1;
  // Count value on the last all-empty edge before falling back to IDLE.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_DLY - 1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [UMB_W-1:0] umb_l_q, umb_l_d;
  logic [UMB_W-1:0] umb_h_q, umb_h_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             all_empty;

  assign all_empty = &bus.empty;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= S_RESET;
      umb_l_q    <= '0;
      umb_h_q    <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      umb_l_q    <= umb_l_d;
      umb_h_q    <= umb_h_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    umb_l_d    = umb_l_q;
    umb_h_d    = umb_h_q;
    idle_cnt_d = idle_cnt_q;
    if (bus.init) begin
      // init overrides everything, including FIFO activity and ERROR.
      state_d    = S_INIT;
      umb_l_d    = bus.umbral_IN_L;
      umb_h_d    = bus.umbral_IN_H;
      idle_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_RESET: state_d = S_INIT;
        S_INIT:  state_d = (umb_l_q < umb_h_q) ? S_IDLE : S_ERROR;
        S_IDLE: begin
          if (!all_empty) begin
            state_d    = S_ACTIVE;
            idle_cnt_d = '0;
          end
        end
        S_ACTIVE: begin
          if (!all_empty) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == CNT_LAST) begin
            state_d    = S_IDLE;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_INIT;
      endcase
    end
  end

  // Moore outputs: decoded from registers only.
  assign bus.umbral_OUT_L = umb_l_q;
  assign bus.umbral_OUT_H = umb_h_q;
  assign bus.idle_out     = (state_q == S_IDLE);
  assign bus.active_out   = (state_q == S_ACTIVE);
  assign bus.error_out    = (state_q == S_ERROR);
  assign bus.state_out    = state_q;

endmodule

// File: tb/tb_fsm_ctrl_param.sv
// tb_fsm_ctrl_param - directed bench for fsm_ctrl_param: default build
// (8 FIFOs, 3-bit thresholds, IDLE_DLY=4) and a small build (4 FIFOs,
// 5-bit thresholds, IDLE_DLY=1).
module tb_fsm_ctrl_param;

  logic clk = 1'b0;
  logic rst1_n, rst2_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fsm_ctrl_param_if #(.N_FIFO(8), .UMB_W(3)) bus1 ();
  fsm_ctrl_param_if #(.N_FIFO(4), .UMB_W(5)) bus2 ();

  fsm_ctrl_param #(.N_FIFO(8), .UMB_W(3), .IDLE_DLY(4)) dut1 (
    .clk(clk), .reset_L(rst1_n), .bus(bus1)
  );
  fsm_ctrl_param #(.N_FIFO(4), .UMB_W(5), .IDLE_DLY(1)) dut2 (
    .clk(clk), .reset_L(rst2_n), .bus(bus2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled there as well.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic st1(input string tag, input int s);
    check({tag, ".state"},  32'(bus1.state_out),  32'(s));
    check({tag, ".idle"},   32'(bus1.idle_out),   32'(s == 2));
    check({tag, ".active"}, 32'(bus1.active_out), 32'(s == 3));
    check({tag, ".error"},  32'(bus1.error_out),  32'(s == 4));
  endtask

  task automatic st2(input string tag, input int s);
    check({tag, ".state"},  32'(bus2.state_out),  32'(s));
    check({tag, ".idle"},   32'(bus2.idle_out),   32'(s == 2));
    check({tag, ".active"}, 32'(bus2.active_out), 32'(s == 3));
    check({tag, ".error"},  32'(bus2.error_out),  32'(s == 4));
  endtask

  task automatic umb1(input string tag, input int l, input int h);
    check({tag, ".umbL"}, 32'(bus1.umbral_OUT_L), 32'(l));
    check({tag, ".umbH"}, 32'(bus1.umbral_OUT_H), 32'(h));
  endtask

  task automatic umb2(input string tag, input int l, input int h);
    check({tag, ".umbL"}, 32'(bus2.umbral_OUT_L), 32'(l));
    check({tag, ".umbH"}, 32'(bus2.umbral_OUT_H), 32'(h));
  endtask

  initial begin
    rst1_n = 1'b0; rst2_n = 1'b0;
    bus1.init = 1'b0; bus1.umbral_IN_L = '0; bus1.umbral_IN_H = '0; bus1.empty = 8'hFF;
    bus2.init = 1'b0; bus2.umbral_IN_L = '0; bus2.umbral_IN_H = '0; bus2.empty = 4'hF;

    // Reset and init: state 0,1,1,1,2
    tick(3);
    st1("rst", 0); umb1("rst", 0, 0);
    rst1_n = 1'b1;
    st1("rel", 0);
    tick(); st1("rst_exit", 1);
    bus1.init = 1'b1; bus1.umbral_IN_L = 3'd2; bus1.umbral_IN_H = 3'd5;
    tick(); st1("init1", 1);
    tick(); st1("init2", 1); umb1("init2", 2, 5);
    bus1.init = 1'b0;
    tick(); st1("to_idle", 2); umb1("to_idle", 2, 5);

    // Equal thresholds -> ERROR, sticky until re-init
    bus1.init = 1'b1; bus1.umbral_IN_L = 3'd5; bus1.umbral_IN_H = 3'd5;
    tick(); st1("bad_init", 1);
    bus1.init = 1'b0;
    tick(); st1("err", 4);
    bus1.empty = 8'h00;
    tick(10); st1("err_hold", 4);
    bus1.empty = 8'hFF;
    bus1.init = 1'b1; bus1.umbral_IN_L = 3'd1; bus1.umbral_IN_H = 3'd6;
    tick(); st1("reinit", 1);
    bus1.init = 1'b0;
    tick(); st1("reinit_idle", 2); umb1("reinit_idle", 1, 6);

    // ACTIVE -> IDLE after exactly 4 all-empty edges
    bus1.empty = 8'hFE;
    tick(); st1("go_act", 3);
    bus1.empty = 8'hFF;
    for (int i = 1; i <= 3; i++) begin
      tick(); st1($sformatf("hyst%0d", i), 3);
    end
    tick(); st1("hyst4", 2);

    // A non-empty sample restarts the count
    bus1.empty = 8'hFE;
    tick(); st1("act2", 3);
    bus1.empty = 8'hFF;
    tick(3); st1("run3", 3);
    bus1.empty = 8'hBF;
    tick(); st1("restart", 3);
    bus1.empty = 8'hFF;
    tick(3); st1("run3b", 3);
    tick(); st1("run4", 2);

    // Thresholds frozen outside init
    for (int i = 0; i < 6; i++) begin
      bus1.umbral_IN_L = 3'($urandom_range(7, 0));
      bus1.umbral_IN_H = 3'($urandom_range(7, 0));
      tick();
    end
    umb1("freeze", 1, 6); st1("freeze", 2);
    bus1.empty = 8'hFE;
    tick(); st1("act3", 3);
    // init beats FIFO activity
    bus1.init = 1'b1; bus1.umbral_IN_L = 3'd3; bus1.umbral_IN_H = 3'd7;
    tick(); st1("init_act", 1); umb1("init_act", 3, 7);
    bus1.init = 1'b0; bus1.empty = 8'hFF;
    tick(); st1("init_act_idle", 2);

    // Async reset mid-ACTIVE, between edges
    bus1.empty = 8'h7F;
    tick(); st1("act4", 3);
    #2 rst1_n = 1'b0;
    #1 st1("arst", 0); umb1("arst", 0, 0);
    tick(); st1("arst_hold", 0);
    rst1_n = 1'b1;

    // Small build, IDLE_DLY=1
    rst2_n = 1'b1;
    tick(); st2("d2_rst_exit", 1);
    bus2.init = 1'b1; bus2.umbral_IN_L = 5'd9; bus2.umbral_IN_H = 5'd4;
    tick(); bus2.init = 1'b0;
    tick(); st2("d2_lgth", 4);
    bus2.init = 1'b1; bus2.umbral_IN_L = 5'd3; bus2.umbral_IN_H = 5'd20;
    tick(); bus2.init = 1'b0;
    st2("d2_init", 1); umb2("d2_init", 3, 20);
    tick(); st2("d2_idle", 2);
    bus2.empty = 4'hE;
    tick(); st2("d2_act", 3);
    bus2.empty = 4'hF;
    tick(); st2("d2_back", 2);
    bus2.empty = 4'h7;
    tick(); st2("d2_act2", 3);
    #3 rst2_n = 1'b0;
    #1 st2("d2_arst", 0); umb2("d2_arst", 0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
